multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle MIPS control unit: a Moore FSM that sequences one instruction over 3–5+ cycles through fetch, decode, execute, memory and writeback, driving the shared-ALU/shared-memory datapath. It generalises the single-cycle main decoder with a memory handshake (`mem_req`/`mem_ready`) and a parametrised wait-state timeout. It also adds a distinct `bne` mode, optional `ori`, and illegal-opcode reporting. It sits between the instruction register (`opcode`), the ALU zero flag, the ALU decoder (`aluop`) and the unified instruction/data memory.

## Interface
- `WAIT_MAX`, 15: maximum stall cycles waiting for `mem_ready`; 0 disables the timeout.
- `ENABLE_BNE`, 1: if 1, 000101 branches on `!zero`; if 0, 000101 behaves as beq.
- `ENABLE_ORI`, 1: if 1, 001101 is decoded; if 0, it is illegal.
- `clk`  in  1  clock, all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `opcode`  in  6  instruction[31:26] from IR; stable from DECODE to end of instruction.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `iord`  out  1  address mux: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  write strobe (valid while `mem_req`).
- `irwrite`  out  1  load IR.
- `pcwrite`  out  1  PC load enable; unconditional and branch terms are already combined.
- `regdst`, `memtoreg`, `regwrite`, `alusrca`  out  1 each  datapath selects/enable.
- `alusrcb`  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc`  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `aluop`  out  2  00 add, 01 sub, 10 funct, 11 or.
- `illegal_op`  out  1  one-cycle pulse, unrecognised opcode.
- `mem_err`  out  1  one-cycle pulse, memory timeout.
- `state`  out  4  current state encoding (debug).

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, IMMWB 10, JUMP 11, ORIEXEC 12. Codes 13–15 are unreachable; if entered, go to FETCH.
- Outputs are a pure decode of `state`, except `pcwrite` in BRANCH and the handshake qualifiers. Any output not listed below is 0.
- FETCH
  - Outputs: `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00.
  - `irwrite` and `pcwrite` are 1 only in a cycle with `mem_ready`=1; that cycle goes to DECODE. Otherwise stay in FETCH.
- DECODE
  - Outputs: `alusrca`=0, `alusrcb`=11, `aluop`=00.
  - Next state by opcode: 000000→EXECUTE; 100011/101011→MEMADR; 000100/000101→BRANCH; 001000→ADDIEXEC; 001101→ORIEXEC (if ENABLE_ORI); 000010→JUMP.
  - Any other opcode: `illegal_op`=1 and go to FETCH.
- MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `mem_req`=1, `iord`=1. On `mem_ready` go to MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0. Then FETCH.
- MEMWRITE: `mem_req`=1, `iord`=1, `memwrite`=1. On `mem_ready` go to FETCH.
- EXECUTE: `alusrca`=1, `alusrcb`=00, `aluop`=10. Then ALUWB.
- ALUWB: `regwrite`=1, `regdst`=1. Then FETCH.
- BRANCH
  - Outputs: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=01.
  - `pcwrite` = `zero` for beq, or for 000101 when ENABLE_BNE=0; `pcwrite` = `!zero` for bne when ENABLE_BNE=1.
  - Then FETCH.
- ADDIEXEC: `alusrca`=1, `alusrcb`=10, `aluop`=00. Then IMMWB.
- ORIEXEC: same as ADDIEXEC but `aluop`=11. Then IMMWB.
- IMMWB: `regwrite`=1, `regdst`=0, `memtoreg`=0. Then FETCH.
- JUMP: `pcsrc`=10, `pcwrite`=1. Then FETCH.
- Wait counter
  - Width clog2(WAIT_MAX+1). Cleared on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle with `mem_req`=1 and `mem_ready`=0.
  - If WAIT_MAX>0 and the counter equals WAIT_MAX with `mem_ready`=0, the FSM aborts: `mem_err`=1 for that cycle, next state FETCH.
  - An abort suppresses `irwrite`, `pcwrite` and `regwrite`.
  - If `mem_ready`=1 in the limit cycle, the access completes normally.

## Timing
- While `reset_n`=0 at a rising edge: state←FETCH and counter←0. While `reset_n` is low, all outputs are forced to 0.
- The first `mem_req` appears in the first cycle after `reset_n` goes high.
- Reset mid-instruction abandons it with no further writes.
- Latency with `mem_ready` tied to 1:
  - R-type: 4 cycles. lw: 5. sw: 4. addi/ori: 4. beq/bne: 3. j: 3. Illegal: 2.
- Each wait cycle adds one cycle to FETCH, MEMREAD or MEMWRITE.
- `mem_ready` is sampled only while `mem_req`=1; it is ignored in all other states.
- `illegal_op` and `mem_err` are never asserted in the same cycle.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles → all outputs 0, `state`=0. Release → next cycle `mem_req`=1, `alusrcb`=01.
- lw with `mem_ready`=1 → state sequence 0,1,2,3,4,0. `regwrite`=1 with `memtoreg`=1 only in state 4. Total 5 cycles.
- R-type with 3-cycle fetch wait (`mem_ready` low 2 cycles) → `irwrite` single pulse on the 3rd FETCH cycle. `regwrite`/`regdst`=1 in ALUWB.
- Branches:
  - bne with ENABLE_BNE=1: `zero`=0 → `pcwrite`=1, `pcsrc`=01 in BRANCH; `zero`=1 → `pcwrite`=0.
  - ENABLE_BNE=0: 000101 with `zero`=1 → `pcwrite`=1.
- Opcode 111111 → `illegal_op` pulse in DECODE, next state FETCH. Opcode 001101 with ENABLE_ORI=0 → same result.
- WAIT_MAX=4, sw with `mem_ready` held 0 → `mem_err` pulses in the 5th MEMWRITE cycle, next state FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, with a timed memory handshake.
module multicycle_controller #(
    parameter int WAIT_MAX   = 15,
    parameter bit ENABLE_BNE = 1'b1,
    parameter bit ENABLE_ORI = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_IMMWB    = 4'd10,
        S_JUMP     = 4'd11,
        S_ORIEXEC  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int            CW       = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_phase, abort;

    logic            mem_req_c, iord_c, memwrite_c, irwrite_c, pcwrite_c;
    logic            regdst_c, memtoreg_c, regwrite_c, alusrca_c;
    logic [1:0]      alusrcb_c, pcsrc_c, aluop_c;
    logic            illegal_c, mem_err_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // mem_ready only matters in the three states that hold mem_req high.
    assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign abort     = (WAIT_MAX > 0) && mem_phase && !mem_ready && (cnt_q == WAIT_LIM);

    always_comb begin
        state_d    = state_q;
        mem_req_c  = 1'b0;
        iord_c     = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        pcwrite_c  = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        alusrca_c  = 1'b0;
        alusrcb_c  = 2'b00;
        pcsrc_c    = 2'b00;
        aluop_c    = 2'b00;
        illegal_c  = 1'b0;
        mem_err_c  = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                alusrcb_c = 2'b01;
                if (mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                case (opcode)
                    OP_RTYPE:       state_d = S_EXECUTE;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:        state_d = S_ADDIEXEC;
                    OP_J:           state_d = S_JUMP;
                    OP_ORI: begin
                        if (ENABLE_ORI) begin
                            state_d = S_ORIEXEC;
                        end else begin
                            illegal_c = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c  = 1'b1;
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca_c = 1'b1;
                aluop_c   = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                regdst_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_c = 1'b1;
                aluop_c   = 2'b01;
                pcsrc_c   = 2'b01;
                pcwrite_c = (ENABLE_BNE && (opcode == OP_BNE)) ? !zero : zero;
                state_d   = S_FETCH;
            end
            S_ADDIEXEC, S_ORIEXEC: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                aluop_c   = (state_q == S_ORIEXEC) ? 2'b11 : 2'b00;
                state_d   = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_c   = 2'b10;
                pcwrite_c = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (abort) begin
            mem_err_c  = 1'b1;
            irwrite_c  = 1'b0;
            pcwrite_c  = 1'b0;
            regwrite_c = 1'b0;
            state_d    = S_FETCH;
        end
    end

    // Counter restarts on every state change (and on an abort back into FETCH) and saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || abort) begin
            cnt_d = '0;
        end else if (mem_phase && !mem_ready && (cnt_q != WAIT_LIM)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign mem_req    = reset_n & mem_req_c;
    assign iord       = reset_n & iord_c;
    assign memwrite   = reset_n & memwrite_c;
    assign irwrite    = reset_n & irwrite_c;
    assign pcwrite    = reset_n & pcwrite_c;
    assign regdst     = reset_n & regdst_c;
    assign memtoreg   = reset_n & memtoreg_c;
    assign regwrite   = reset_n & regwrite_c;
    assign alusrca    = reset_n & alusrca_c;
    assign alusrcb    = {2{reset_n}} & alusrcb_c;
    assign pcsrc      = {2{reset_n}} & pcsrc_c;
    assign aluop      = {2{reset_n}} & aluop_c;
    assign illegal_op = reset_n & illegal_c;
    assign mem_err    = reset_n & mem_err_c;
    assign state      = reset_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: default-parameter instance A and a
// WAIT_MAX=4 / no-bne / no-ori instance B, checked cycle by cycle against hand-written vectors.
module tb_multicycle_controller;

    logic       clk;
    logic       reset_a, reset_b;
    logic [5:0] opcode;
    logic       zero, mem_ready;

    logic       mr_a, io_a, mw_a, irw_a, pcw_a, rd_a, m2r_a, rw_a, asa_a, ill_a, me_a;
    logic [1:0] asb_a, pcs_a, aop_a;
    logic [3:0] st_a;
    logic       mr_b, io_b, mw_b, irw_b, pcw_b, rd_b, m2r_b, rw_b, asa_b, ill_b, me_b;
    logic [1:0] asb_b, pcs_b, aop_b;
    logic [3:0] st_b;

    multicycle_controller dut_a (
        .clk(clk), .reset_n(reset_a), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mr_a), .iord(io_a), .memwrite(mw_a), .irwrite(irw_a), .pcwrite(pcw_a),
        .regdst(rd_a), .memtoreg(m2r_a), .regwrite(rw_a), .alusrca(asa_a),
        .alusrcb(asb_a), .pcsrc(pcs_a), .aluop(aop_a),
        .illegal_op(ill_a), .mem_err(me_a), .state(st_a)
    );

    multicycle_controller #(.WAIT_MAX(4), .ENABLE_BNE(1'b0), .ENABLE_ORI(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_b), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mr_b), .iord(io_b), .memwrite(mw_b), .irwrite(irw_b), .pcwrite(pcw_b),
        .regdst(rd_b), .memtoreg(m2r_b), .regwrite(rw_b), .alusrca(asa_b),
        .alusrcb(asb_b), .pcsrc(pcs_b), .aluop(aop_b),
        .illegal_op(ill_b), .mem_err(me_b), .state(st_b)
    );

    // Vector layout: {mem_req,iord,memwrite,irwrite,pcwrite,regdst,memtoreg,regwrite,alusrca},
    // alusrcb, pcsrc, aluop, {illegal_op,mem_err}, state
    logic [20:0] vec_a, vec_b;
    assign vec_a = {mr_a, io_a, mw_a, irw_a, pcw_a, rd_a, m2r_a, rw_a, asa_a,
                    asb_a, pcs_a, aop_a, ill_a, me_a, st_a};
    assign vec_b = {mr_b, io_b, mw_b, irw_b, pcw_b, rd_b, m2r_b, rw_b, asa_b,
                    asb_b, pcs_b, aop_b, ill_b, me_b, st_b};

    localparam logic [20:0] E_RST   = 21'd0;
    localparam logic [20:0] E_FW    = {9'b100000000, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0};
    localparam logic [20:0] E_FG    = {9'b100110000, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0};
    localparam logic [20:0] E_FERR  = {9'b100000000, 2'b01, 2'b00, 2'b00, 2'b01, 4'd0};
    localparam logic [20:0] E_DEC   = {9'b000000000, 2'b11, 2'b00, 2'b00, 2'b00, 4'd1};
    localparam logic [20:0] E_DILL  = {9'b000000000, 2'b11, 2'b00, 2'b00, 2'b10, 4'd1};
    localparam logic [20:0] E_MADR  = {9'b000000001, 2'b10, 2'b00, 2'b00, 2'b00, 4'd2};
    localparam logic [20:0] E_MRD   = {9'b110000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd3};
    localparam logic [20:0] E_MWB   = {9'b000000110, 2'b00, 2'b00, 2'b00, 2'b00, 4'd4};
    localparam logic [20:0] E_MWR   = {9'b111000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'd5};
    localparam logic [20:0] E_MWERR = {9'b111000000, 2'b00, 2'b00, 2'b00, 2'b01, 4'd5};
    localparam logic [20:0] E_EXE   = {9'b000000001, 2'b00, 2'b00, 2'b10, 2'b00, 4'd6};
    localparam logic [20:0] E_AWB   = {9'b000001010, 2'b00, 2'b00, 2'b00, 2'b00, 4'd7};
    localparam logic [20:0] E_BRT   = {9'b000010001, 2'b00, 2'b01, 2'b01, 2'b00, 4'd8};
    localparam logic [20:0] E_BRN   = {9'b000000001, 2'b00, 2'b01, 2'b01, 2'b00, 4'd8};
    localparam logic [20:0] E_ADDI  = {9'b000000001, 2'b10, 2'b00, 2'b00, 2'b00, 4'd9};
    localparam logic [20:0] E_IMMWB = {9'b000000010, 2'b00, 2'b00, 2'b00, 2'b00, 4'd10};
    localparam logic [20:0] E_JMP   = {9'b000010000, 2'b00, 2'b10, 2'b00, 2'b00, 4'd11};
    localparam logic [20:0] E_ORI   = {9'b000000001, 2'b10, 2'b00, 2'b11, 2'b00, 4'd12};

    typedef struct {
        string       name;
        bit          sel_b;
        logic [20:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle with a pending expectation, compare mid-cycle.
    exp_t       mon_e;
    logic [20:0] mon_act;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = mon_e.sel_b ? vec_b : vec_a;
            n_checks++;
            if (mon_act !== mon_e.exp) begin
                n_fails++;
                $display("FAIL %s (dut_%s): got %06h expected %06h",
                         mon_e.name, mon_e.sel_b ? "b" : "a", mon_act, mon_e.exp);
            end
        end
    end

    task automatic cyc(input string name, input bit sel_b, input logic rdy, input logic z,
                       input logic [20:0] exp);
        exp_t e;
        mem_ready = rdy;
        zero      = z;
        e.name    = name;
        e.sel_b   = sel_b;
        e.exp     = exp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_a = 1'b0; reset_b = 1'b0;
        opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- instance A: defaults ----------------
        for (int i = 0; i < 3; i++) cyc("reset_hold", 0, 1'b1, 1'b1, E_RST);
        reset_a = 1'b1;

        opcode = 6'b100011;                       // lw, no waits
        cyc("lw_fetch",  0, 1'b1, 1'b0, E_FG);
        cyc("lw_decode", 0, 1'b1, 1'b0, E_DEC);
        cyc("lw_memadr", 0, 1'b1, 1'b0, E_MADR);
        cyc("lw_memrd",  0, 1'b1, 1'b0, E_MRD);
        cyc("lw_memwb",  0, 1'b1, 1'b0, E_MWB);

        opcode = 6'b000000;                       // R-type with 3-cycle fetch
        cyc("r_fetch_w1", 0, 1'b0, 1'b0, E_FW);
        cyc("r_fetch_w2", 0, 1'b0, 1'b0, E_FW);
        cyc("r_fetch_go", 0, 1'b1, 1'b0, E_FG);
        cyc("r_decode",   0, 1'b0, 1'b0, E_DEC);
        cyc("r_execute",  0, 1'b0, 1'b0, E_EXE);
        cyc("r_aluwb",    0, 1'b0, 1'b0, E_AWB);

        opcode = 6'b101011;                       // sw
        cyc("sw_fetch",  0, 1'b1, 1'b0, E_FG);
        cyc("sw_decode", 0, 1'b1, 1'b0, E_DEC);
        cyc("sw_memadr", 0, 1'b1, 1'b0, E_MADR);
        cyc("sw_memwr",  0, 1'b1, 1'b0, E_MWR);

        opcode = 6'b001000;                       // addi
        cyc("addi_fetch",  0, 1'b1, 1'b0, E_FG);
        cyc("addi_decode", 0, 1'b1, 1'b0, E_DEC);
        cyc("addi_exec",   0, 1'b1, 1'b0, E_ADDI);
        cyc("addi_immwb",  0, 1'b1, 1'b0, E_IMMWB);

        opcode = 6'b001101;                       // ori
        cyc("ori_fetch",  0, 1'b1, 1'b0, E_FG);
        cyc("ori_decode", 0, 1'b1, 1'b0, E_DEC);
        cyc("ori_exec",   0, 1'b1, 1'b0, E_ORI);
        cyc("ori_immwb",  0, 1'b1, 1'b0, E_IMMWB);

        opcode = 6'b000100;                       // beq taken / not taken
        cyc("beq_t_fetch",  0, 1'b1, 1'b1, E_FG);
        cyc("beq_t_decode", 0, 1'b1, 1'b1, E_DEC);
        cyc("beq_t_branch", 0, 1'b1, 1'b1, E_BRT);
        cyc("beq_n_fetch",  0, 1'b1, 1'b0, E_FG);
        cyc("beq_n_decode", 0, 1'b1, 1'b0, E_DEC);
        cyc("beq_n_branch", 0, 1'b1, 1'b0, E_BRN);

        opcode = 6'b000101;                       // bne: taken when zero=0
        cyc("bne_t_fetch",  0, 1'b1, 1'b0, E_FG);
        cyc("bne_t_decode", 0, 1'b1, 1'b0, E_DEC);
        cyc("bne_t_branch", 0, 1'b1, 1'b0, E_BRT);
        cyc("bne_n_fetch",  0, 1'b1, 1'b1, E_FG);
        cyc("bne_n_decode", 0, 1'b1, 1'b1, E_DEC);
        cyc("bne_n_branch", 0, 1'b1, 1'b1, E_BRN);

        opcode = 6'b000010;                       // j
        cyc("j_fetch",  0, 1'b1, 1'b0, E_FG);
        cyc("j_decode", 0, 1'b1, 1'b0, E_DEC);
        cyc("j_jump",   0, 1'b1, 1'b0, E_JMP);

        opcode = 6'b111111;                       // illegal
        cyc("ill_fetch",  0, 1'b1, 1'b0, E_FG);
        cyc("ill_decode", 0, 1'b1, 1'b0, E_DILL);

        opcode = 6'b100011;                       // lw with two MEMREAD waits
        cyc("lww_fetch",  0, 1'b1, 1'b0, E_FG);
        cyc("lww_decode", 0, 1'b0, 1'b0, E_DEC);
        cyc("lww_memadr", 0, 1'b0, 1'b0, E_MADR);
        cyc("lww_memrd1", 0, 1'b0, 1'b0, E_MRD);
        cyc("lww_memrd2", 0, 1'b0, 1'b0, E_MRD);
        cyc("lww_memrd3", 0, 1'b1, 1'b0, E_MRD);
        cyc("lww_memwb",  0, 1'b1, 1'b0, E_MWB);

        // reset mid-instruction abandons the lw
        cyc("abn_fetch",  0, 1'b1, 1'b0, E_FG);
        cyc("abn_decode", 0, 1'b1, 1'b0, E_DEC);
        reset_a = 1'b0;
        cyc("abn_reset",  0, 1'b1, 1'b0, E_RST);
        reset_a = 1'b1;
        cyc("abn_refetch", 0, 1'b0, 1'b0, E_FW);
        reset_a = 1'b0;

        // ---------------- instance B: WAIT_MAX=4, bne off, ori off ----------------
        cyc("b_reset", 1, 1'b1, 1'b0, E_RST);
        reset_b = 1'b1;

        opcode = 6'b000101;                       // behaves as beq
        cyc("b5_t_fetch",  1, 1'b1, 1'b1, E_FG);
        cyc("b5_t_decode", 1, 1'b1, 1'b1, E_DEC);
        cyc("b5_t_branch", 1, 1'b1, 1'b1, E_BRT);
        cyc("b5_n_fetch",  1, 1'b1, 1'b0, E_FG);
        cyc("b5_n_decode", 1, 1'b1, 1'b0, E_DEC);
        cyc("b5_n_branch", 1, 1'b1, 1'b0, E_BRN);

        opcode = 6'b001101;                       // ori disabled -> illegal
        cyc("bori_fetch",  1, 1'b1, 1'b0, E_FG);
        cyc("bori_decode", 1, 1'b1, 1'b0, E_DILL);

        opcode = 6'b101011;                       // sw timeout on 5th MEMWRITE cycle
        cyc("bsw_fetch",  1, 1'b1, 1'b0, E_FG);
        cyc("bsw_decode", 1, 1'b0, 1'b0, E_DEC);
        cyc("bsw_memadr", 1, 1'b0, 1'b0, E_MADR);
        for (int i = 0; i < 4; i++) cyc("bsw_memwr_wait", 1, 1'b0, 1'b0, E_MWR);
        cyc("bsw_memwr_err", 1, 1'b0, 1'b0, E_MWERR);

        // fetch timeout, then the counter restarts for the retried fetch
        for (int i = 0; i < 4; i++) cyc("bf_wait", 1, 1'b0, 1'b0, E_FW);
        cyc("bf_err",   1, 1'b0, 1'b0, E_FERR);
        cyc("bf_retry", 1, 1'b0, 1'b0, E_FW);
        cyc("bf_go",    1, 1'b1, 1'b0, E_FG);

        // mem_ready arriving exactly in the limit cycle completes normally
        opcode = 6'b100011;
        cyc("blim_decode", 1, 1'b0, 1'b0, E_DEC);
        cyc("blim_memadr", 1, 1'b0, 1'b0, E_MADR);
        for (int i = 0; i < 4; i++) cyc("blim_memrd_wait", 1, 1'b0, 1'b0, E_MRD);
        cyc("blim_memrd_done", 1, 1'b1, 1'b0, E_MRD);
        cyc("blim_memwb",      1, 1'b0, 1'b0, E_MWB);
        cyc("blim_back",       1, 1'b0, 1'b0, E_FW);

        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
